// File: rtl/hazard_pkg.sv
// Shared hazard encodings: forward-select codes, Tuse/Tnew constants for the decoder, shadow slot types.
// Combinational helpers only; no state.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam logic [1:0] TUSE_BRANCH     = 2'd0;
    localparam logic [1:0] TUSE_JR         = 2'd0;
    localparam logic [1:0] TUSE_ALU        = 2'd1;
    localparam logic [1:0] TUSE_MEM_BASE   = 2'd1;
    localparam logic [1:0] TUSE_STORE_DATA = 2'd2;

    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_MFHI = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } slot_t;

    // M only ever forwards store data, so its rs is not carried.
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
        logic [4:0] rt;
    } mslot_t;

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic reg_hit(input logic [4:0] r, input logic [4:0] wa);
        return (r != 5'd0) && (r == wa);
    endfunction

endpackage

// File: rtl/hazard_md_busy.sv
// Multiply/divide busy tracker: loads a cycle count when a start enters E, counts down to idle.
// md_stall is combinational from registered state and md_use; no backpressure of its own.
module hazard_md_busy
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic clk,
    input  logic reset,
    input  logic issue,
    input  logic is_div,
    input  logic md_use,
    output logic md_stall
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0] state_q;
    logic [3:0] cnt_q;
    logic       e_start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            e_start_q <= 1'b0;
        end else begin
            e_start_q <= issue;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= BUSY;
                        cnt_q   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_stall = md_use && ((state_q == BUSY) || e_start_q);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M/W destination pipeline drives stall and all forward selects.
// Outputs combinational from slot state and D inputs; HAZARD_MD_EN adds the mult/div busy stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_MULT_CYCLES = 5,
    parameter int MD_DIV_CYCLES  = 10
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
`ifdef HAZARD_MD_EN
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
`endif
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    slot_t      e_q;
    mslot_t     m_q;
    logic [4:0] w_wa_q;
    logic       stall_rs;
    logic       stall_rt;
    logic       md_stall;

    function automatic logic [1:0] sel_d(input logic [4:0] r, input slot_t e,
                                         input mslot_t m, input logic [4:0] w);
        if (reg_hit(r, e.wa) && e.tnew == 2'd0)      return FWD_E;
        else if (reg_hit(r, m.wa) && m.tnew == 2'd0) return FWD_M;
        else if (reg_hit(r, w))                      return FWD_W;
        else                                         return FWD_RF;
    endfunction

    function automatic logic [1:0] sel_e(input logic [4:0] r, input mslot_t m,
                                         input logic [4:0] w);
        if (reg_hit(r, m.wa) && m.tnew == 2'd0) return FWD_M;
        else if (reg_hit(r, w))                 return FWD_W;
        else                                    return FWD_RF;
    endfunction

    assign stall_rs = (reg_hit(d_rs, e_q.wa) && (e_q.tnew > d_tuse_rs)) ||
                      (reg_hit(d_rs, m_q.wa) && (m_q.tnew > d_tuse_rs));
    assign stall_rt = (reg_hit(d_rt, e_q.wa) && (e_q.tnew > d_tuse_rt)) ||
                      (reg_hit(d_rt, m_q.wa) && (m_q.tnew > d_tuse_rt));
    assign stall    = stall_rs || stall_rt || md_stall;

    assign fwd_d_rs = sel_d(d_rs, e_q, m_q, w_wa_q);
    assign fwd_d_rt = sel_d(d_rt, e_q, m_q, w_wa_q);
    assign fwd_e_rs = sel_e(e_q.rs, m_q, w_wa_q);
    assign fwd_e_rt = sel_e(e_q.rt, m_q, w_wa_q);
    assign fwd_m_rt = reg_hit(m_q.rt, w_wa_q);

    // M and W advance unconditionally; only E chooses between D and a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_wa_q <= 5'd0;
        end else begin
            m_q.wa   <= e_q.wa;
            m_q.tnew <= tnew_dec(e_q.tnew);
            m_q.rt   <= e_q.rt;
            w_wa_q   <= m_q.wa;
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q.wa   <= d_wa;
                e_q.tnew <= d_tnew;
                e_q.rs   <= d_rs;
                e_q.rt   <= d_rt;
            end
        end
    end

`ifdef HAZARD_MD_EN
    hazard_md_busy #(
        .MULT_CYCLES (MD_MULT_CYCLES),
        .DIV_CYCLES  (MD_DIV_CYCLES)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .issue    (d_md_start && !stall),
        .is_div   (d_md_div),
        .md_use   (d_md_use),
        .md_stall (md_stall)
    );
`else
    assign md_stall = 1'b0;
`endif

endmodule
